multimode_ff_bank: RTL and testbench

//   WIDTH-bit bank of flip-flops, each bit run as SR, JK, D or T per a shared runtime mode.

---
 rtl/multimode_ff_bank.sv | 123 ++++++++++++
 tb/tb_multimode_ff_bank.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit flip-flop bank where every bit behaves as SR, JK, D or T per a shared runtime mode.
// Illegal SR 11 inputs resolve per SR11_MODE and are logged in sticky per-bit flags and a saturating counter.
module multimode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = '0,
  parameter int               SR11_MODE = 0,
  parameter int               CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] err_bits,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0]       MODE_SR = 2'b00;
  localparam logic [1:0]       MODE_JK = 2'b01;
  localparam logic [1:0]       MODE_D  = 2'b10;
  localparam logic [1:0]       MODE_T  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] illegal;
  logic             any_illegal;
  logic [WIDTH-1:0] err_bits_next;
  logic [CNT_W-1:0] err_cnt_next;

  // Resolution of s=r=1; anything other than set/reset-dominant holds.
  function automatic logic sr11_bit(input logic cur);
    logic res;
    if (SR11_MODE == 32'sd1) begin
      res = 1'b1;
    end else if (SR11_MODE == 32'sd2) begin
      res = 1'b0;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  function automatic logic next_bit(input logic [1:0] m, input logic cur,
                                    input logic x, input logic y);
    logic nb;
    nb = cur;
    case (m)
      MODE_SR: begin
        case ({x, y})
          2'b01:   nb = 1'b0;
          2'b10:   nb = 1'b1;
          2'b11:   nb = sr11_bit(cur);
          default: nb = cur;
        endcase
      end
      MODE_JK: begin
        case ({x, y})
          2'b01:   nb = 1'b0;
          2'b10:   nb = 1'b1;
          2'b11:   nb = ~cur;
          default: nb = cur;
        endcase
      end
      MODE_D:  nb = x;
      MODE_T:  nb = cur ^ x;
      default: nb = cur;
    endcase
    return nb;
  endfunction

  // Next flip-flop state for all bits.
  always_comb begin
    q_next = q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        q_next[i] = next_bit(mode, q[i], a[i], b[i]);
      end
    end else begin
      q_next = q;
    end
  end

  // Error detection ignores en; a fresh event wins over err_clr.
  always_comb begin
    illegal       = '0;
    err_bits_next = err_bits;
    err_cnt_next  = err_cnt;
    if (mode == MODE_SR) begin
      illegal = a & b;
    end else begin
      illegal = '0;
    end
    any_illegal   = |illegal;
    err_bits_next = (err_clr ? '0 : err_bits) | illegal;
    if (err_clr) begin
      err_cnt_next = any_illegal ? CNT_W'(1'b1) : '0;
    end else if (any_illegal && (err_cnt != CNT_MAX)) begin
      err_cnt_next = err_cnt + CNT_W'(1'b1);
    end else begin
      err_cnt_next = err_cnt;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q        <= RST_VAL;
      err_bits <= '0;
      err_cnt  <= '0;
    end else begin
      q        <= q_next;
      err_bits <= err_bits_next;
      err_cnt  <= err_cnt_next;
    end
  end

  assign q_bar = ~q;

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Scoreboard bench for multimode_ff_bank: three instances differing only in SR11_MODE share stimulus;
// the stimulus pushes hand-computed expectations and a separate monitor pops and compares them.
module tb_multimode_ff_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       err_clr = 1'b0;
  logic       probe = 1'b0;

  logic [7:0] q_o  [3];
  logic [7:0] qb_o [3];
  logic [7:0] eb_o [3];
  logic [1:0] ec_o [3];

  typedef struct {
    string          name;
    logic [2:0][7:0] q;
    logic [7:0]     eb;
    logic [1:0]     ec;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multimode_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR11_MODE(0), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q_o[0]), .q_bar(qb_o[0]), .err_bits(eb_o[0]), .err_cnt(ec_o[0]));
  multimode_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR11_MODE(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q_o[1]), .q_bar(qb_o[1]), .err_bits(eb_o[1]), .err_cnt(ec_o[1]));
  multimode_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5), .SR11_MODE(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q_o[2]), .q_bar(qb_o[2]), .err_bits(eb_o[2]), .err_cnt(ec_o[2]));

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: after each clock edge (or an async-reset probe) compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge probe);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("%s q[%0d]", e.name, k), q_o[k], e.q[k]);
          chk($sformatf("%s q_bar[%0d]", e.name, k), qb_o[k], ~e.q[k]);
          chk($sformatf("%s err_bits[%0d]", e.name, k), eb_o[k], e.eb);
          chk($sformatf("%s err_cnt[%0d]", e.name, k), {6'd0, ec_o[k]}, {6'd0, e.ec});
        end
      end
    end
  end

  task automatic push(input string nm, input logic [7:0] q0, input logic [7:0] q1,
                      input logic [7:0] q2, input logic [7:0] eb, input logic [1:0] ec);
    exp_t e;
    e.name = nm;
    e.q[0] = q0;
    e.q[1] = q1;
    e.q[2] = q2;
    e.eb   = eb;
    e.ec   = ec;
    sb.push_back(e);
  endtask

  task automatic step(input string nm, input logic e_i, input logic [1:0] m_i,
                      input logic [7:0] a_i, input logic [7:0] b_i, input logic clr_i,
                      input logic [7:0] q0, input logic [7:0] q1, input logic [7:0] q2,
                      input logic [7:0] eb, input logic [1:0] ec);
    @(negedge clk);
    en      = e_i;
    mode    = m_i;
    a       = a_i;
    b       = b_i;
    err_clr = clr_i;
    push(nm, q0, q1, q2, eb, ec);
  endtask

  task automatic async_reset_check(input string nm);
    push(nm, 8'hA5, 8'hA5, 8'hA5, 8'h00, 2'd0);
    probe = 1'b1;
    #2;
    probe = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    async_reset_check("reset_init");
    @(negedge clk);
    rst = 1'b0;

    //        name         en    mode   a      b      clr   q0     q1     q2     eb     ec
    step("d_load",     1'b1, 2'b10, 8'h0F, 8'h00, 1'b0, 8'h0F, 8'h0F, 8'h0F, 8'h00, 2'd0);
    step("jk_tog1",    1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, 8'hF0, 8'hF0, 8'hF0, 8'h00, 2'd0);
    step("jk_tog2",    1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, 8'h0F, 8'h0F, 8'h0F, 8'h00, 2'd0);
    step("sr11_03",    1'b1, 2'b00, 8'h03, 8'h03, 1'b0, 8'h0F, 8'h0F, 8'h0C, 8'h03, 2'd1);
    step("sr11_f0",    1'b1, 2'b00, 8'hF0, 8'hF0, 1'b0, 8'h0F, 8'hFF, 8'h0C, 8'hF3, 2'd2);
    step("sat1_clr",   1'b1, 2'b00, 8'h01, 8'h01, 1'b1, 8'h0F, 8'hFF, 8'h0C, 8'h01, 2'd1);
    step("sat2",       1'b1, 2'b00, 8'h01, 8'h01, 1'b0, 8'h0F, 8'hFF, 8'h0C, 8'h01, 2'd2);
    step("sat3",       1'b1, 2'b00, 8'h01, 8'h01, 1'b0, 8'h0F, 8'hFF, 8'h0C, 8'h01, 2'd3);
    step("sat4",       1'b1, 2'b00, 8'h01, 8'h01, 1'b0, 8'h0F, 8'hFF, 8'h0C, 8'h01, 2'd3);
    step("sat5",       1'b1, 2'b00, 8'h01, 8'h01, 1'b0, 8'h0F, 8'hFF, 8'h0C, 8'h01, 2'd3);
    step("clr_vs_b7",  1'b1, 2'b00, 8'h80, 8'h80, 1'b1, 8'h0F, 8'hFF, 8'h0C, 8'h80, 2'd1);
    step("en0_d_clr",  1'b0, 2'b10, 8'hFF, 8'h00, 1'b1, 8'h0F, 8'hFF, 8'h0C, 8'h00, 2'd0);
    step("en0_sr11",   1'b0, 2'b00, 8'h02, 8'h02, 1'b0, 8'h0F, 8'hFF, 8'h0C, 8'h02, 2'd1);
    step("d_3c",       1'b1, 2'b10, 8'h3C, 8'hFF, 1'b0, 8'h3C, 8'h3C, 8'h3C, 8'h02, 2'd1);
    step("t_0f",       1'b1, 2'b11, 8'h0F, 8'hFF, 1'b0, 8'h33, 8'h33, 8'h33, 8'h02, 2'd1);
    step("t_00",       1'b1, 2'b11, 8'h00, 8'hFF, 1'b0, 8'h33, 8'h33, 8'h33, 8'h02, 2'd1);
    step("sr_reset",   1'b1, 2'b00, 8'h00, 8'h30, 1'b0, 8'h03, 8'h03, 8'h03, 8'h02, 2'd1);
    step("sr_set",     1'b1, 2'b00, 8'hC0, 8'h00, 1'b0, 8'hC3, 8'hC3, 8'hC3, 8'h02, 2'd1);
    step("jk_setrst",  1'b1, 2'b01, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'hF0, 8'hF0, 8'h02, 2'd1);
    step("jk_hold",    1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 8'hF0, 8'hF0, 8'hF0, 8'h02, 2'd1);

    @(posedge clk);
    #3;
    rst = 1'b1;
    async_reset_check("reset_mid");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
